layer_priority_mixer: RTL and testbench

//  Parametrised N-layer pixel compositor between the sprite/HUD generators and the VGA driver.

---
 rtl/layer_priority_mixer.sv | 190 +++++++++++++++++++
 tb/tb_layer_priority_mixer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/layer_priority_mixer.sv
// layer_priority_mixer: N-layer priority pixel compositor with frame-synced screen select and hit blink.
// Latency: fixed 2 clk from pixel inputs to rgb_out/hit_layer/hit_valid; one pixel per clk.
// Backpressure: none; the pixel stream never stalls. Build option: COLOR_KEY_EN makes KEY_RGB transparent.
module layer_priority_mixer #(
    parameter int               LAYERS       = 8,
    parameter int               RGB_W        = 12,
    parameter logic [RGB_W-1:0] KEY_RGB      = RGB_W'(12'hF0F),
    parameter int               FLASH_FRAMES = 32,
    parameter int               BLINK_FRAMES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame_start,
    input  logic                      blank,
    input  logic [1:0]                mode,
    input  logic [LAYERS-1:0]         layer_en,
    input  logic [LAYERS*RGB_W-1:0]   layer_rgb,
    input  logic [RGB_W-1:0]          bg_rgb,
    input  logic [RGB_W-1:0]          start_rgb,
    input  logic [RGB_W-1:0]          end_rgb,
    input  logic                      flash_req,
    output logic [RGB_W-1:0]          rgb_out,
    output logic [$clog2(LAYERS)-1:0] hit_layer,
    output logic                      hit_valid,
    output logic                      flash_active
);

    localparam int IDX_W = $clog2(LAYERS);
    localparam logic [7:0] LAST_FRAME = 8'(FLASH_FRAMES - 1);
    localparam logic [7:0] BLINK_DIV  = 8'(BLINK_FRAMES);

    // With the key disabled the comparator term folds to a constant and disappears.
`ifdef COLOR_KEY_EN
    localparam logic KEY_EN = 1'b1;
`else
    localparam logic KEY_EN = 1'b0;
`endif

    typedef enum logic {
        IDLE  = 1'b0,
        FLASH = 1'b1
    } state_t;

    state_t            state;
    logic [7:0]        frame_cnt;
    logic [7:0]        blink_idx;
    logic              blink_off;
    logic [1:0]        mode_q;

    logic [LAYERS-1:0] opaque;
    logic [IDX_W-1:0]  win_idx;
    logic [RGB_W-1:0]  win_rgb;
    logic              any_opaque;
    logic [RGB_W-1:0]  base_rgb;

    logic [IDX_W-1:0]  idx_s1;
    logic [RGB_W-1:0]  rgb_s1;
    logic              any_s1;
    logic              blank_s1;
    logic              play_s1;
    logic [RGB_W-1:0]  base_s1;

    // Screen select only changes on the frame boundary so a frame is never split between screens.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q <= 2'd0;
        end else if (frame_start) begin
            mode_q <= mode;
        end
    end

    // Flash sequencer: counts frames since the last hit; a new hit always restarts the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            frame_cnt    <= 8'd0;
            flash_active <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (flash_req) begin
                        state        <= FLASH;
                        frame_cnt    <= 8'd0;
                        flash_active <= 1'b1;
                    end
                end
                FLASH: begin
                    if (flash_req) begin
                        frame_cnt <= 8'd0;
                    end else if (frame_start) begin
                        if (frame_cnt == LAST_FRAME) begin
                            state        <= IDLE;
                            frame_cnt    <= 8'd0;
                            flash_active <= 1'b0;
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    state        <= IDLE;
                    frame_cnt    <= 8'd0;
                    flash_active <= 1'b0;
                end
            endcase
        end
    end

    // Player is hidden during odd blink half-periods; frame_cnt only moves at frame_start.
    assign blink_idx = frame_cnt / BLINK_DIV;
    assign blink_off = (state == FLASH) & blink_idx[0];

    // Per-layer opacity: coverage, player blink mask, optional colour key.
    always_comb begin
        opaque = '0;
        for (int i = 0; i < LAYERS; i++) begin
            opaque[i] = layer_en[i]
                      & ~((i == 0) & blink_off)
                      & (~KEY_EN | (layer_rgb[i*RGB_W +: RGB_W] != KEY_RGB));
        end
    end

    // Priority select: scanning from the lowest priority upward leaves the lowest opaque index.
    always_comb begin
        win_idx    = '0;
        win_rgb    = '0;
        any_opaque = 1'b0;
        for (int i = LAYERS - 1; i >= 0; i--) begin
            if (opaque[i]) begin
                win_idx    = IDX_W'(i);
                win_rgb    = layer_rgb[i*RGB_W +: RGB_W];
                any_opaque = 1'b1;
            end
        end
    end

    // Base pixel for the current screen; the reserved mode shows black.
    always_comb begin
        case (mode_q)
            2'd0:    base_rgb = start_rgb;
            2'd1:    base_rgb = bg_rgb;
            2'd2:    base_rgb = end_rgb;
            default: base_rgb = '0;
        endcase
    end

    // Stage 1: register the winner and base; the play flag travels with the pixel so both
    // stages agree on the mode even when mode_q changes between them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_s1   <= '0;
            rgb_s1   <= '0;
            any_s1   <= 1'b0;
            blank_s1 <= 1'b0;
            play_s1  <= 1'b0;
            base_s1  <= '0;
        end else begin
            idx_s1   <= win_idx;
            rgb_s1   <= win_rgb;
            any_s1   <= any_opaque;
            blank_s1 <= blank;
            play_s1  <= (mode_q == 2'd1);
            base_s1  <= base_rgb;
        end
    end

    // Stage 2: final composite; layers only count on the play screen and blanking forces black.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rgb_out   <= '0;
            hit_layer <= '0;
            hit_valid <= 1'b0;
        end else begin
            if (blank_s1) begin
                rgb_out   <= '0;
                hit_layer <= '0;
                hit_valid <= 1'b0;
            end else if (play_s1 && any_s1) begin
                rgb_out   <= rgb_s1;
                hit_layer <= idx_s1;
                hit_valid <= 1'b1;
            end else begin
                rgb_out   <= base_s1;
                hit_layer <= '0;
                hit_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_layer_priority_mixer.sv
// tb_layer_priority_mixer: randomized pixel/frame/flash stimulus against a frame-level reference model.
// Latency: expectations are formed when inputs are sampled and compared two clocks later.
// Backpressure: none; one pixel is driven every clock.
module tb_layer_priority_mixer;

    localparam int LAYERS       = 8;
    localparam int RGB_W        = 12;
    localparam int FLASH_FRAMES = 8;
    localparam int BLINK_FRAMES = 2;
    localparam int FRAME_LEN    = 7;
    localparam logic [RGB_W-1:0] KEY = 12'hF0F;

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic                     frame_start = 1'b0;
    logic                     blank = 1'b0;
    logic [1:0]               mode = 2'd0;
    logic [LAYERS-1:0]        layer_en = '0;
    logic [LAYERS*RGB_W-1:0]  layer_rgb = '0;
    logic [RGB_W-1:0]         bg_rgb = '0;
    logic [RGB_W-1:0]         start_rgb = '0;
    logic [RGB_W-1:0]         end_rgb = '0;
    logic                     flash_req = 1'b0;
    logic [RGB_W-1:0]         rgb_out;
    logic [2:0]               hit_layer;
    logic                     hit_valid;
    logic                     flash_active;

    layer_priority_mixer #(
        .LAYERS(LAYERS), .RGB_W(RGB_W), .KEY_RGB(KEY),
        .FLASH_FRAMES(FLASH_FRAMES), .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .blank(blank), .mode(mode),
        .layer_en(layer_en), .layer_rgb(layer_rgb), .bg_rgb(bg_rgb), .start_rgb(start_rgb),
        .end_rgb(end_rgb), .flash_req(flash_req), .rgb_out(rgb_out), .hit_layer(hit_layer),
        .hit_valid(hit_valid), .flash_active(flash_active)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: screen in effect, flash activity and whole frames elapsed since the last hit.
    int m_mode    = 0;
    bit m_active  = 1'b0;
    int m_elapsed = 0;
    int fpos      = 0;

    // Expectation for the pixel currently emerging from the pipeline.
    logic [RGB_W-1:0] p_rgb = '0;
    logic [2:0]       p_hl  = '0;
    logic             p_hv  = 1'b0;
    bit               p_vld = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected pixel for the inputs at this edge, using the screen/blink in effect before the edge.
    task automatic model_pixel(output logic [RGB_W-1:0] e_rgb, output logic [2:0] e_hl, output logic e_hv);
        int win;
        bit hide0;
        logic [RGB_W-1:0] c;
        logic [RGB_W-1:0] base;
        hide0 = m_active && (((m_elapsed / BLINK_FRAMES) % 2) == 1);
        win = -1;
        for (int i = 0; i < LAYERS; i++) begin
            c = layer_rgb[i*RGB_W +: RGB_W];
            if (win < 0 && layer_en[i] && !(i == 0 && hide0)) begin
`ifdef COLOR_KEY_EN
                if (c != KEY) win = i;
`else
                win = i;
`endif
            end
        end
        case (m_mode)
            0:       base = start_rgb;
            1:       base = bg_rgb;
            2:       base = end_rgb;
            default: base = '0;
        endcase
        if (blank) begin
            e_rgb = '0; e_hl = '0; e_hv = 1'b0;
        end else if (m_mode == 1 && win >= 0) begin
            e_rgb = layer_rgb[win*RGB_W +: RGB_W];
            e_hl  = 3'(win);
            e_hv  = 1'b1;
        end else begin
            e_rgb = base; e_hl = '0; e_hv = 1'b0;
        end
    endtask

    task automatic model_update();
        if (frame_start) m_mode = int'(mode);
        if (flash_req) begin
            m_active  = 1'b1;
            m_elapsed = 0;
        end else if (frame_start && m_active) begin
            m_elapsed++;
            if (m_elapsed >= FLASH_FRAMES) m_active = 1'b0;
        end
    endtask

    task automatic drive_random();
        fpos        = (fpos + 1) % FRAME_LEN;
        frame_start = (fpos == 0);
        blank       = ($urandom_range(0, 4) == 0);
        if ($urandom_range(0, 14) == 0) mode = 2'($urandom_range(0, 3));
        for (int i = 0; i < LAYERS; i++) begin
            layer_en[i] = (i == 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) == 0);
            layer_rgb[i*RGB_W +: RGB_W] = ($urandom_range(0, 3) == 0) ? KEY : RGB_W'($urandom);
        end
        bg_rgb    = RGB_W'($urandom);
        start_rgb = RGB_W'($urandom);
        end_rgb   = RGB_W'($urandom);
        flash_req = ($urandom_range(0, 39) == 0);
        // Aim hits at the last frame boundary of a sequence now and then.
        if (frame_start && m_active && m_elapsed == FLASH_FRAMES - 1 && $urandom_range(0, 1) == 1)
            flash_req = 1'b1;
    endtask

    task automatic run_cycle();
        logic [RGB_W-1:0] e_rgb;
        logic [2:0]       e_hl;
        logic             e_hv;
        @(posedge clk);
        model_pixel(e_rgb, e_hl, e_hv);
        model_update();
        #1;
        if (p_vld) begin
            check_val("rgb_out", 32'(rgb_out), 32'(p_rgb));
            check_val("hit_layer", 32'(hit_layer), 32'(p_hl));
            check_val("hit_valid", 32'(hit_valid), 32'(p_hv));
        end
        check_val("flash_active", 32'(flash_active), 32'(m_active));
        p_rgb = e_rgb; p_hl = e_hl; p_hv = e_hv; p_vld = 1'b1;
        drive_random();
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_rgb"}, 32'(rgb_out), 32'd0);
        check_val({tag, "_hit_layer"}, 32'(hit_layer), 32'd0);
        check_val({tag, "_hit_valid"}, 32'(hit_valid), 32'd0);
        check_val({tag, "_flash"}, 32'(flash_active), 32'd0);
    endtask

    // Enter a flash on the end screen, then reset mid-frame away from the clock edge.
    task automatic reset_mid_flash();
        flash_req = 1'b1; frame_start = 1'b1; mode = 2'd2; fpos = 0;
        run_cycle();
        run_cycle();
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_zero("async_rst");
        m_mode = 0; m_active = 1'b0; m_elapsed = 0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("held_rst");
        #3;
        rst = 1'b1;
        // Stage 2 first shows the cleared stage 1 contents, then live pixels.
        p_rgb = '0; p_hl = '0; p_hv = 1'b0; p_vld = 1'b1;
    endtask

    initial begin
        #2;
        check_zero("por");
        frame_start = 1'b1;
        fpos = 0;
        #10;
        rst = 1'b1;
        p_vld = 1'b1;
        for (int n = 0; n < 6000; n++) begin
            run_cycle();
            if (n % 1500 == 1499) reset_mid_flash();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
